retry_arbiter: RTL and testbench

- Shares one retry_start-side retry channel between NumSources retry_end-side producers. Typical producers are several checker lanes that each request retries of IDs.
- Faces each producer as a "start" endpoint: takes id/valid/lock in, drives ready/id_feedback out.
- Faces the single downstream retry_start as an "ende" endpoint.
- Round-robin arbitration, a lock-hold state machine, and a one-entry output register slice.

---
 rtl/retry_arbiter_pkg.sv | 15 +
 rtl/retry_arbiter_rr.sv | 37 +++
 rtl/retry_arbiter.sv | 163 ++++++++++++++++
 tb/tb_retry_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/retry_arbiter_pkg.sv
// Shared types and helpers for the retry arbiter: FSM state encoding and
// round-robin pointer increment.
package retry_arbiter_pkg;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_e;

    // Wrapped increment of a round-robin pointer over n entries.
    function automatic int rr_next(input int ptr, input int n);
        return ((ptr + 32'sd1) >= n) ? 32'sd0 : (ptr + 32'sd1);
    endfunction

endpackage

// File: rtl/retry_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// wrapping modulo NumSources. With no requester the grant rests on ptr_i.
module retry_arbiter_rr #(
    parameter int NumSources = 2,
    parameter int SrcW       = 1
) (
    input  logic [NumSources-1:0] req_i,
    input  logic [SrcW-1:0]       ptr_i,
    output logic [SrcW-1:0]       grant_o,
    output logic                  any_req_o
);

    // Scan from the pointer upward and keep the first hit.
    always_comb begin
        logic [SrcW:0]   sum_s;
        logic [SrcW-1:0] idx_s;
        logic            hit_s;
        grant_o   = ptr_i;
        any_req_o = 1'b0;
        sum_s     = '0;
        idx_s     = '0;
        hit_s     = 1'b0;
        for (int i = 0; i < NumSources; i++) begin
            sum_s = {1'b0, ptr_i} + (SrcW+1)'(i);
            if (sum_s >= (SrcW+1)'(NumSources)) begin
                sum_s = sum_s - (SrcW+1)'(NumSources);
            end else begin
                sum_s = sum_s;
            end
            idx_s     = sum_s[SrcW-1:0];
            hit_s     = !any_req_o && req_i[idx_s];
            grant_o   = hit_s ? idx_s : grant_o;
            any_req_o = any_req_o | hit_s;
        end
    end

endmodule

// File: rtl/retry_arbiter.sv
// Round-robin retry arbiter with lock hold and a one-entry output slice.
// Optional per-source saturating counters when RETRY_ARBITER_STATS_EN is defined.
module retry_arbiter
    import retry_arbiter_pkg::*;
#(
    parameter int NumSources = 2,
    parameter int IDSize     = 4,
    parameter int CntWidth   = 16,
    localparam int SrcW      = (NumSources > 1) ? $clog2(NumSources) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumSources*IDSize-1:0] src_id_i,
    input  logic [NumSources-1:0]        src_valid_i,
    output logic [NumSources-1:0]        src_ready_o,
    input  logic [NumSources-1:0]        src_lock_i,
    output logic [IDSize-1:0]            src_id_feedback_o,
    output logic [IDSize-1:0]            dst_id_o,
    output logic                         dst_valid_o,
    input  logic                         dst_ready_i,
    output logic                         dst_lock_o,
    input  logic [IDSize-1:0]            dst_id_feedback_i,
    output logic [SrcW-1:0]              dst_src_o
`ifdef RETRY_ARBITER_STATS_EN
    ,
    output logic [NumSources*CntWidth-1:0] retry_cnt_o,
    input  logic                           cnt_clear_i
`endif
);

    arb_state_e        state_r, state_s;
    logic [SrcW-1:0]   rr_ptr_r, rr_ptr_s;
    logic [SrcW-1:0]   lock_src_r, lock_src_s;
    logic [SrcW-1:0]   eff_ptr_s, pick_grant_s, grant_s;
    logic              any_req_s, locked_hold_s, accept_s, hs_s;
    logic              dst_valid_r;
    logic [IDSize-1:0] dst_id_r;
    logic [SrcW-1:0]   dst_src_r;
    logic [IDSize-1:0] id_arr_s [NumSources];

    for (genvar g = 0; g < NumSources; g++) begin : g_id_unpack
        assign id_arr_s[g] = src_id_i[g*IDSize +: IDSize];
    end

    // A lock only holds while its owner keeps asserting lock; in the exit
    // cycle arbitration already restarts just after the former owner.
    assign locked_hold_s = (state_r == LOCKED) && src_lock_i[lock_src_r];
    assign eff_ptr_s     = (state_r == LOCKED) ? SrcW'(rr_next(int'(lock_src_r), NumSources))
                                               : rr_ptr_r;

    retry_arbiter_rr #(
        .NumSources (NumSources),
        .SrcW       (SrcW)
    ) u_rr (
        .req_i     (src_valid_i),
        .ptr_i     (eff_ptr_s),
        .grant_o   (pick_grant_s),
        .any_req_o (any_req_s)
    );

    assign grant_s  = locked_hold_s ? lock_src_r : pick_grant_s;
    assign accept_s = !dst_valid_r || dst_ready_i;
    assign hs_s     = accept_s && src_valid_i[grant_s];

    // Ready goes only to the granted source while the slice can accept.
    always_comb begin
        src_ready_o = '0;
        for (int g = 0; g < NumSources; g++) begin
            src_ready_o[g] = accept_s && (grant_s == SrcW'(g));
        end
    end

    // Lock FSM next-state and round-robin pointer update.
    always_comb begin
        state_s    = state_r;
        rr_ptr_s   = rr_ptr_r;
        lock_src_s = lock_src_r;
        case (state_r)
            LOCKED: begin
                if (locked_hold_s) begin
                    state_s = LOCKED;
                end else if (hs_s && src_lock_i[grant_s]) begin
                    lock_src_s = grant_s;
                    rr_ptr_s   = eff_ptr_s;
                end else if (hs_s) begin
                    state_s  = UNLOCKED;
                    rr_ptr_s = SrcW'(rr_next(int'(grant_s), NumSources));
                end else begin
                    state_s  = UNLOCKED;
                    rr_ptr_s = eff_ptr_s;
                end
            end
            UNLOCKED: begin
                if (hs_s && src_lock_i[grant_s]) begin
                    state_s    = LOCKED;
                    lock_src_s = grant_s;
                end else if (hs_s) begin
                    rr_ptr_s = SrcW'(rr_next(int'(grant_s), NumSources));
                end else begin
                    state_s = UNLOCKED;
                end
            end
            default: begin
                state_s  = UNLOCKED;
                rr_ptr_s = '0;
            end
        endcase
    end

    // FSM, pointer and lock owner registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= UNLOCKED;
            rr_ptr_r   <= '0;
            lock_src_r <= '0;
        end else begin
            state_r    <= state_s;
            rr_ptr_r   <= rr_ptr_s;
            lock_src_r <= lock_src_s;
        end
    end

    // One-entry output slice; a load in a draining cycle replaces the entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dst_valid_r <= 1'b0;
            dst_id_r    <= '0;
            dst_src_r   <= '0;
        end else if (hs_s) begin
            dst_valid_r <= 1'b1;
            dst_id_r    <= id_arr_s[grant_s];
            dst_src_r   <= grant_s;
        end else if (dst_ready_i) begin
            dst_valid_r <= 1'b0;
        end
    end

    assign dst_valid_o       = dst_valid_r;
    assign dst_id_o          = dst_id_r;
    assign dst_src_o         = dst_src_r;
    // Held entries also keep the downstream from reusing IDs.
    assign dst_lock_o        = (|src_lock_i) || (state_r == LOCKED) || dst_valid_r;
    assign src_id_feedback_o = dst_id_feedback_i;

`ifdef RETRY_ARBITER_STATS_EN
    logic [CntWidth-1:0] cnt_r [NumSources];

    for (genvar g = 0; g < NumSources; g++) begin : g_cnt
        // Saturating per-source handshake counter; clear wins over increment.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_r[g] <= '0;
            end else if (cnt_clear_i) begin
                cnt_r[g] <= '0;
            end else if (hs_s && (grant_s == SrcW'(g)) && !(&cnt_r[g])) begin
                cnt_r[g] <= cnt_r[g] + {{(CntWidth-1){1'b0}}, 1'b1};
            end
        end
        assign retry_cnt_o[g*CntWidth +: CntWidth] = cnt_r[g];
    end
`endif

endmodule

// File: tb/tb_retry_arbiter.sv
// Directed bench for retry_arbiter with three sources.
module tb_retry_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [11:0] src_id_i;
    logic [2:0]  src_valid_i;
    logic [2:0]  src_ready_o;
    logic [2:0]  src_lock_i;
    logic [3:0]  src_id_feedback_o;
    logic [3:0]  dst_id_o;
    logic        dst_valid_o;
    logic        dst_ready_i;
    logic        dst_lock_o;
    logic [3:0]  dst_id_feedback_i;
    logic [1:0]  dst_src_o;
`ifdef RETRY_ARBITER_STATS_EN
    logic [47:0] retry_cnt_o;
    logic        cnt_clear_i;
`endif

    int total = 0;
    int bad   = 0;

    retry_arbiter #(
        .NumSources (3),
        .IDSize     (4),
        .CntWidth   (16)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .src_id_i          (src_id_i),
        .src_valid_i       (src_valid_i),
        .src_ready_o       (src_ready_o),
        .src_lock_i        (src_lock_i),
        .src_id_feedback_o (src_id_feedback_o),
        .dst_id_o          (dst_id_o),
        .dst_valid_o       (dst_valid_o),
        .dst_ready_i       (dst_ready_i),
        .dst_lock_o        (dst_lock_o),
        .dst_id_feedback_i (dst_id_feedback_i),
        .dst_src_o         (dst_src_o)
`ifdef RETRY_ARBITER_STATS_EN
        ,
        .retry_cnt_o       (retry_cnt_o),
        .cnt_clear_i       (cnt_clear_i)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    logic [3:0] exp_id  [4] = '{4'd5, 4'd6, 4'd7, 4'd5};
    logic [1:0] exp_src [4] = '{2'd0, 2'd1, 2'd2, 2'd0};

    initial begin
        rst_i             = 1'b1;
        src_id_i          = 12'h000;
        src_valid_i       = 3'b000;
        src_lock_i        = 3'b000;
        dst_ready_i       = 1'b1;
        dst_id_feedback_i = 4'h0;
`ifdef RETRY_ARBITER_STATS_EN
        cnt_clear_i       = 1'b0;
`endif
        repeat (2) @(posedge clk_i);
        #1;
        check_val("rst_valid", 32'(dst_valid_o), 32'd0);
        check_val("rst_id",    32'(dst_id_o),    32'd0);
        check_val("rst_src",   32'(dst_src_o),   32'd0);
        rst_i = 1'b0;

        // Round robin over three always-valid sources.
        src_id_i    = {4'd7, 4'd6, 4'd5};
        src_valid_i = 3'b111;
        #1;
        for (int k = 0; k < 4; k++) begin
            check_val("rr_ready", 32'(src_ready_o), 32'(3'b001 << exp_src[k]));
            tick();
            check_val("rr_valid", 32'(dst_valid_o), 32'd1);
            check_val("rr_id",    32'(dst_id_o),    32'(exp_id[k]));
            check_val("rr_src",   32'(dst_src_o),   32'(exp_src[k]));
        end
        src_valid_i = 3'b000;
        tick();
        check_val("drain_valid", 32'(dst_valid_o), 32'd0);

        // Backpressure holds the entry; next accept in the cycle ready rises.
        src_id_i    = {4'd0, 4'd0, 4'd3};
        src_valid_i = 3'b001;
        dst_ready_i = 1'b0;
        #1;
        check_val("bp_ready0", 32'(src_ready_o), 32'b001);
        tick();
        check_val("bp_load", 32'(dst_id_o), 32'd3);
        src_id_i = {4'd0, 4'd0, 4'd4};
        for (int k = 0; k < 4; k++) begin
            check_val("bp_stall_ready", 32'(src_ready_o), 32'b000);
            check_val("bp_hold_valid",  32'(dst_valid_o), 32'd1);
            check_val("bp_hold_id",     32'(dst_id_o),    32'd3);
            tick();
        end
        dst_ready_i = 1'b1;
        #1;
        check_val("bp_ready_rise", 32'(src_ready_o), 32'b001);
        tick();
        check_val("bp_next_id", 32'(dst_id_o), 32'd4);
        src_valid_i = 3'b000;
        tick();
        check_val("bp_drain", 32'(dst_valid_o), 32'd0);

        // Lock hold by source 1, then round robin from pointer 2.
        src_id_i    = {4'd2, 4'd9, 4'd1};
        src_valid_i = 3'b011;
        src_lock_i  = 3'b010;
        #1;
        check_val("lk_ready_a", 32'(src_ready_o), 32'b010);
        check_val("lk_dlock_a", 32'(dst_lock_o),  32'd1);
        tick();
        check_val("lk_id_a",  32'(dst_id_o),  32'd9);
        check_val("lk_src_a", 32'(dst_src_o), 32'd1);
        src_id_i    = {4'd2, 4'd10, 4'd1};
        src_valid_i = 3'b111;
        #1;
        check_val("lk_ready_b", 32'(src_ready_o), 32'b010);
        tick();
        check_val("lk_id_b", 32'(dst_id_o), 32'd10);
        src_valid_i = 3'b101;
        #1;
        check_val("lk_ready_c", 32'(src_ready_o), 32'b010);
        check_val("lk_dlock_c", 32'(dst_lock_o),  32'd1);
        tick();
        check_val("lk_stall_valid", 32'(dst_valid_o), 32'd0);
        check_val("lk_ready_d",     32'(src_ready_o), 32'b010);
        src_lock_i = 3'b000;
        #1;
        check_val("lk_exit_ready", 32'(src_ready_o), 32'b100);
        tick();
        check_val("lk_exit_id",  32'(dst_id_o),    32'd2);
        check_val("lk_exit_src", 32'(dst_src_o),   32'd2);
        check_val("lk_ready_e",  32'(src_ready_o), 32'b001);
        tick();
        check_val("lk_after_id",  32'(dst_id_o),  32'd1);
        check_val("lk_after_src", 32'(dst_src_o), 32'd0);
        src_valid_i = 3'b000;
        tick();
        check_val("lk_idle_dlock", 32'(dst_lock_o), 32'd0);

        // Feedback passthrough and lock OR.
        dst_id_feedback_i = 4'hA;
        #1;
        check_val("fb_pass", 32'(src_id_feedback_o), 32'hA);
        src_lock_i = 3'b100;
        #1;
        check_val("lockor_on", 32'(dst_lock_o), 32'd1);
        src_lock_i = 3'b000;
        #1;
        check_val("lockor_off", 32'(dst_lock_o), 32'd0);

        // Asynchronous reset while locked and stalled.
        src_id_i    = {4'd0, 4'd12, 4'd0};
        src_valid_i = 3'b010;
        src_lock_i  = 3'b010;
        dst_ready_i = 1'b0;
        #1;
        check_val("rs_ready", 32'(src_ready_o), 32'b010);
        tick();
        check_val("rs_loaded", 32'(dst_valid_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check_val("rs_async_valid", 32'(dst_valid_o), 32'd0);
        check_val("rs_async_id",    32'(dst_id_o),    32'd0);
        src_lock_i  = 3'b000;
        src_valid_i = 3'b000;
        #2;
        rst_i = 1'b0;
        #1;
        check_val("rs_unlocked", 32'(dst_lock_o), 32'd0);
        src_id_i    = {4'd0, 4'd14, 4'd13};
        src_valid_i = 3'b011;
        dst_ready_i = 1'b1;
        #1;
        check_val("rs_first_ready", 32'(src_ready_o), 32'b001);
        tick();
        check_val("rs_first_src", 32'(dst_src_o), 32'd0);
        check_val("rs_first_id",  32'(dst_id_o),  32'd13);
        src_valid_i = 3'b000;
        tick();

`ifdef RETRY_ARBITER_STATS_EN
        // Saturating counter and clear priority.
        cnt_clear_i = 1'b1;
        tick();
        cnt_clear_i = 1'b0;
        check_val("cnt_cleared", 32'(retry_cnt_o[15:0]), 32'd0);
        src_id_i    = {4'd0, 4'd0, 4'd5};
        src_valid_i = 3'b001;
        repeat (70000) @(posedge clk_i);
        #1;
        check_val("cnt_sat",  32'(retry_cnt_o[15:0]),  32'hFFFF);
        check_val("cnt_src1", 32'(retry_cnt_o[31:16]), 32'd0);
        cnt_clear_i = 1'b1;
        tick();
        cnt_clear_i = 1'b0;
        check_val("cnt_clr_prio", 32'(retry_cnt_o[15:0]), 32'd0);
        tick();
        check_val("cnt_resume", 32'(retry_cnt_o[15:0]), 32'd1);
        src_valid_i = 3'b000;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
